issue_queue: RTL and testbench
==============================

Name: issue_queue

Overview:
- Instruction FIFO on the fetch-to-decode path.
- Acts as the responder for the fetch stage's issue handshake. It accepts instructions when issue_valid_i and issue_ready_o are both high.
- Buffers up to DEPTH instructions and presents them in order to the decode stage on a valid/ready interface.
- Supports a single-cycle flush for exceptions and mispredictions.

Parameters:
- DEPTH, 8, number of entries. Must be a power of two and at least 2.
- ILEN, from mmm_pkg, instruction width in bits.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_n_i  in  1  reset; synchronous, active-low.
- flush_i  in  1  discard all buffered instructions.
- issue_valid_i  in  1  fetch stage has an instruction on instruction_i.
- issue_ready_o  out  1  queue can accept an instruction this cycle.
- instruction_i  in  ILEN  instruction from the fetch stage.
- instr_valid_o  out  1  instruction_o holds a valid instruction.
- instr_ready_i  in  1  decode stage accepts instruction_o this cycle.
- instruction_o  out  ILEN  oldest buffered instruction.
- count_o  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.

Behaviour:
- Storage:
  - Circular buffer of DEPTH x ILEN entries.
  - Read and write pointers are $clog2(DEPTH)+1 bits wide; the MSB is the wrap bit.
  - empty = (rd_ptr == wr_ptr).
  - full = (index bits equal) and (wrap bits differ).
- Reset (rst_n_i low at a rising edge):
  - Both pointers go to 0 and count_o goes to 0.
  - Storage contents are not reset.
  - Outputs in the cycle after reset: issue_ready_o=1, instr_valid_o=0, count_o=0.
  - instruction_o is don't-care when instr_valid_o=0.
  - Reset overrides flush and any push or pop in the same cycle.
- Push:
  - Occurs when issue_valid_i && issue_ready_o && !flush_i.
  - Writes instruction_i at wr_ptr, then increments wr_ptr.
- Pop:
  - Occurs when instr_valid_o && instr_ready_i && !flush_i.
  - Increments rd_ptr.
- Ready/valid generation:
  - issue_ready_o = !full && !flush_i (combinational).
  - instr_valid_o = !empty && !flush_i (combinational).
  - instruction_o = mem[rd_ptr index] (combinational read).
- Latency: an instruction pushed in cycle N is visible on instruction_o in cycle N+1 (bypass off).
- Simultaneous push and pop:
  - Not full, not empty: both pointers advance; count_o unchanged.
  - Full: no push, because issue_ready_o=0. The pop proceeds and count_o becomes DEPTH-1. issue_ready_o is high in the next cycle.
  - Empty: no pop, because instr_valid_o=0. The push proceeds and count_o becomes 1.
- Wrap-around: pointers wrap modulo 2*DEPTH with no stall and no loss of ordering.
- Flush:
  - When flush_i is high at an edge, rd_ptr is set to wr_ptr and count_o goes to 0 in the next cycle.
  - During the flush cycle, no push or pop takes place, even if the handshake signals are high.
- count_o:
  - Registered; equals wr_ptr - rd_ptr (modulo 2*DEPTH).
  - Never exceeds DEPTH.
- Handshake rules:
  - Once instr_valid_o is high, instruction_o stays stable until popped or flushed.
  - The queue never drops an accepted instruction except on flush or reset.

Optional Feature:
- Macro: ISSUE_QUEUE_BYPASS_EN.
- When defined:
  - If the queue is empty, issue_valid_i=1 and flush_i=0, then instr_valid_o=1 and instruction_o=instruction_i combinationally.
  - If instr_ready_i is also high, the instruction is consumed in the same cycle and not stored; pointers and count_o are unchanged. This gives zero-cycle latency.
  - If instr_ready_i is low, the instruction is pushed as normal.
- When not defined: behaviour is exactly as above, with a minimum of 1-cycle latency and no combinational path from instruction_i to instruction_o.

Test Plan:
- Fill, then drain:
  - Stimulus: hold instr_ready_i=0 and push 0x00000013, 0x00100093, ... (8 distinct values).
  - Response: count_o goes 1 to 8; issue_ready_o=0 after the 8th push.
  - Stimulus: then set instr_ready_i=1.
  - Response: the 8 values appear in order on consecutive cycles; count_o returns to 0.
- Full with simultaneous pop:
  - Stimulus: at count_o=8, assert issue_valid_i=1 and instr_ready_i=1.
  - Response: only the pop occurs and count_o=7; the next cycle's push is accepted and count_o=8.
- Streaming and wrap-around:
  - Stimulus: push and pop every cycle for 40 cycles with incrementing values 1..40.
  - Response: output sequence is 1..40 with 1-cycle latency (bypass off); count_o stays at 1.
- Flush:
  - Stimulus: with count_o=5, assert flush_i for 1 cycle while issue_valid_i=1.
  - Response: issue_ready_o=0 and instr_valid_o=0 during the flush cycle; count_o=0 next cycle; the pending instruction is not stored.
- Reset mid-operation:
  - Stimulus: with count_o=6, drive rst_n_i=0 for 1 edge.
  - Response: count_o=0, instr_valid_o=0, issue_ready_o=1; a subsequent push of 0xDEADBEEF is the first value output.
- Bypass (ISSUE_QUEUE_BYPASS_EN defined):
  - Stimulus: with the queue empty, push 0x12345678 with instr_ready_i=1.
  - Response: instruction_o=0x12345678 and instr_valid_o=1 in the same cycle; count_o stays 0.

Source files
------------

// File: rtl/issue_queue.sv
// ============================================================================
// Module   : issue_queue (with supporting package mmm_pkg)
// Purpose  : Instruction FIFO between the fetch and decode stages. Fetch
//            pushes on a valid/ready handshake. Decode pops the oldest entry
//            in order. flush_i discards every buffered instruction in one
//            cycle.
// Ports    : clk_i          clock, rising edge
//            rst_n_i        synchronous active-low reset
//            flush_i        discard all buffered instructions
//            issue_valid_i  fetch offers instruction_i
//            issue_ready_o  queue can accept an instruction this cycle
//            instruction_i  instruction from fetch (ILEN bits)
//            instr_valid_o  instruction_o is valid
//            instr_ready_i  decode accepts instruction_o this cycle
//            instruction_o  oldest buffered instruction (ILEN bits)
//            count_o        occupancy, 0..DEPTH
// Options  : ISSUE_QUEUE_BYPASS_EN. When this macro is defined, an empty
//            queue forwards instruction_i straight to instruction_o. If
//            decode takes the instruction in that same cycle, it is never
//            stored.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mmm_pkg;
  localparam int ILEN = 32;
endpackage

module issue_queue #(
  parameter int DEPTH = 8,
  parameter int ILEN  = mmm_pkg::ILEN
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic                     flush_i,
  input  logic                     issue_valid_i,
  output logic                     issue_ready_o,
  input  logic [ILEN-1:0]          instruction_i,
  output logic                     instr_valid_o,
  input  logic                     instr_ready_i,
  output logic [ILEN-1:0]          instruction_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [ILEN-1:0] mem [DEPTH];
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   count_q;

  logic empty;
  logic full;
  logic push;
  logic pop;

  assign empty = (rd_ptr == wr_ptr);
  // Equal index bits with differing wrap bits means the writer is a full
  // lap ahead of the reader.
  assign full  = (rd_ptr[AW-1:0] == wr_ptr[AW-1:0]) && (rd_ptr[AW] != wr_ptr[AW]);

  assign issue_ready_o = !full && !flush_i;

`ifdef ISSUE_QUEUE_BYPASS_EN
  logic bypass;
  assign bypass        = empty && issue_valid_i && !flush_i;
  assign instr_valid_o = (!empty || bypass) && !flush_i;
  assign instruction_o = bypass ? instruction_i : mem[rd_ptr[AW-1:0]];
  // An instruction forwarded and consumed in the same cycle is never stored.
  assign push = issue_valid_i && issue_ready_o && !flush_i && !(bypass && instr_ready_i);
  // Only stored entries move the read pointer. A bypassed hand-off leaves
  // both pointers untouched.
  assign pop  = !empty && instr_ready_i && !flush_i;
`else
  assign instr_valid_o = !empty && !flush_i;
  assign instruction_o = mem[rd_ptr[AW-1:0]];
  assign push = issue_valid_i && issue_ready_o && !flush_i;
  assign pop  = instr_valid_o && instr_ready_i && !flush_i;
`endif

  assign count_o = count_q;

  // Storage is not reset. Writes are blocked while reset is asserted, so
  // reset takes precedence over a push in the same cycle.
  always_ff @(posedge clk_i) begin
    if (rst_n_i && push) begin
      mem[wr_ptr[AW-1:0]] <= instruction_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
    end else if (flush_i) begin
      rd_ptr  <= wr_ptr;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count_q <= count_q + PW'(push) - PW'(pop);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_issue_queue.sv
// ============================================================================
// Module   : tb_issue_queue
// Purpose  : Directed self-checking bench for issue_queue (DEPTH=8, ILEN=32).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_issue_queue;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        flush_i;
  logic        issue_valid_i;
  logic        issue_ready_o;
  logic [31:0] instruction_i;
  logic        instr_valid_o;
  logic        instr_ready_i;
  logic [31:0] instruction_o;
  logic [3:0]  count_o;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] vals [8];

  always #5 clk_i = ~clk_i;

  issue_queue #(.DEPTH(8), .ILEN(32)) dut (
    .clk_i         (clk_i),
    .rst_n_i       (rst_n_i),
    .flush_i       (flush_i),
    .issue_valid_i (issue_valid_i),
    .issue_ready_o (issue_ready_o),
    .instruction_i (instruction_i),
    .instr_valid_o (instr_valid_o),
    .instr_ready_i (instr_ready_i),
    .instruction_o (instruction_o),
    .count_o       (count_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    rst_n_i = 1'b0; flush_i = 1'b0; issue_valid_i = 1'b0;
    instr_ready_i = 1'b0; instruction_i = '0;
    tick();
    rst_n_i = 1'b1;
    #1;
    check("rst_count", 32'(count_o), 0);
    check("rst_iready", 32'(issue_ready_o), 1);
    check("rst_ivalid", 32'(instr_valid_o), 0);

    // Fill: addi xi, x0, i -> 0x13, 0x00100093, 0x00200113, ...
    for (int i = 0; i < 8; i++)
      vals[i] = 32'h13 | (32'(i) << 20) | (32'(i) << 7);
    for (int i = 0; i < 8; i++) begin
      issue_valid_i = 1'b1; instruction_i = vals[i];
      #1;
      check("fill_iready", 32'(issue_ready_o), 1);
      tick();
      check("fill_count", 32'(count_o), 32'(i + 1));
    end
    check("full_iready", 32'(issue_ready_o), 0);

    // Full with a simultaneous offer and pop: only the pop happens.
    issue_valid_i = 1'b1; instruction_i = 32'hAAAA0000; instr_ready_i = 1'b1;
    #1;
    check("fullpop_head", instruction_o, vals[0]);
    check("fullpop_valid", 32'(instr_valid_o), 1);
    tick();
    check("fullpop_count", 32'(count_o), 7);
    check("fullpop_iready", 32'(issue_ready_o), 1);
    instr_ready_i = 1'b0;
    tick();
    check("refill_count", 32'(count_o), 8);

    // Drain: vals[1..7], then 0xAAAA0000, on consecutive cycles.
    issue_valid_i = 1'b0; instr_ready_i = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      #1;
      check("drain_valid", 32'(instr_valid_o), 1);
      check("drain_data", instruction_o, (i == 8) ? 32'hAAAA0000 : vals[i]);
      tick();
    end
    check("drain_count", 32'(count_o), 0);
    check("drain_empty", 32'(instr_valid_o), 0);

    // Streaming across several pointer wraps: 1..40 with 1-cycle latency.
    issue_valid_i = 1'b1; instruction_i = 32'd1;
    tick();
    for (int k = 1; k <= 40; k++) begin
      issue_valid_i = (k < 40); instruction_i = 32'(k + 1);
      #1;
      check("stream_count", 32'(count_o), 1);
      check("stream_data", instruction_o, 32'(k));
      tick();
    end
    check("stream_end_count", 32'(count_o), 0);

    // Flush with five entries and a concurrent offer.
    instr_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      issue_valid_i = 1'b1; instruction_i = 32'h50 + 32'(i);
      tick();
    end
    check("preflush_count", 32'(count_o), 5);
    flush_i = 1'b1; instruction_i = 32'hBAD0BAD0; instr_ready_i = 1'b1;
    #1;
    check("flush_iready", 32'(issue_ready_o), 0);
    check("flush_ivalid", 32'(instr_valid_o), 0);
    tick();
    flush_i = 1'b0; issue_valid_i = 1'b0; instr_ready_i = 1'b0;
    #1;
    check("postflush_count", 32'(count_o), 0);
    check("postflush_valid", 32'(instr_valid_o), 0);
    issue_valid_i = 1'b1; instruction_i = 32'h77;
    tick();
    issue_valid_i = 1'b0; instr_ready_i = 1'b1;
    #1;
    check("postflush_data", instruction_o, 32'h77);
    check("postflush_cnt1", 32'(count_o), 1);
    tick();
    instr_ready_i = 1'b0;

    // Reset in the middle of operation, with six entries held.
    for (int i = 0; i < 6; i++) begin
      issue_valid_i = 1'b1; instruction_i = 32'h60 + 32'(i);
      tick();
    end
    issue_valid_i = 1'b0;
    check("prerst_count", 32'(count_o), 6);
    rst_n_i = 1'b0;
    tick();
    rst_n_i = 1'b1;
    #1;
    check("midrst_count", 32'(count_o), 0);
    check("midrst_ivalid", 32'(instr_valid_o), 0);
    check("midrst_iready", 32'(issue_ready_o), 1);
    issue_valid_i = 1'b1; instruction_i = 32'hDEADBEEF;
    tick();
    issue_valid_i = 1'b0; instr_ready_i = 1'b1;
    #1;
    check("midrst_first", instruction_o, 32'hDEADBEEF);
    check("midrst_fvalid", 32'(instr_valid_o), 1);
    tick();
    check("midrst_drained", 32'(count_o), 0);

`ifdef ISSUE_QUEUE_BYPASS_EN
    issue_valid_i = 1'b1; instruction_i = 32'h12345678; instr_ready_i = 1'b1;
    #1;
    check("byp_valid", 32'(instr_valid_o), 1);
    check("byp_data", instruction_o, 32'h12345678);
    tick();
    issue_valid_i = 1'b0;
    #1;
    check("byp_count", 32'(count_o), 0);
`else
    // Without bypass, an offer into an empty queue must not show up yet.
    issue_valid_i = 1'b1; instruction_i = 32'h12345678; instr_ready_i = 1'b1;
    #1;
    check("nobyp_valid", 32'(instr_valid_o), 0);
    tick();
    issue_valid_i = 1'b0;
    #1;
    check("nobyp_data", instruction_o, 32'h12345678);
    check("nobyp_count", 32'(count_o), 1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
